regfile_scoreboard: RTL and testbench

//   Parametrised register file for the SIMPLE decode stage: NRD read ports, one writeback port,

---
 rtl/regfile_scoreboard.sv | 112 +++++++++++
 tb/tb_regfile_scoreboard.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file: NRD registered read ports, one writeback port with
// write-first bypass, and a per-register pending-write scoreboard that stalls hazards.
module regfile_scoreboard #(
  parameter int DATA_W  = 16,
  parameter int NREGS   = 8,
  parameter int ADDR_W  = 3,
  parameter int NRD     = 2,
  parameter int R0_ZERO = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [NRD-1:0]           rd_use,
  input  logic [NRD*ADDR_W-1:0]    rd_addr,
  input  logic                     dst_en,
  input  logic [ADDR_W-1:0]        dst_addr,
  output logic [NRD*DATA_W-1:0]    rd_data,
  output logic                     rd_valid,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  output logic [NREGS-1:0]         pending,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);

  // Handshake: an instruction is accepted on a rising edge where issue_valid and
  // issue_ready are both 1. issue_ready depends only on the offered operands, the
  // scoreboard and the current writeback, never on issue_valid, so decode may hold
  // its offer (valid high, fields stable) until ready rises. rd_valid pulses for
  // exactly one cycle after each acceptance; there is no back-pressure on it.

  logic [DATA_W-1:0]      regs [NREGS];
  logic [ADDR_W-1:0]      src_addr [NRD];
  logic [NRD-1:0]         src_haz;
  logic [NRD*DATA_W-1:0]  operands;
  logic [DATA_W-1:0]      dbg_val;
  logic                   wb_ok;
  logic                   dst_ok;
  logic                   dst_haz;
  logic                   accept;

  // Address names a real, writable register (out-of-range and hardwired r0 excluded).
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W+1)'(NREGS)) && !((R0_ZERO != 0) && (a == '0));
  endfunction

  function automatic logic pend_at(input logic [NREGS-1:0] pv, input logic [ADDR_W-1:0] a);
    logic hit;
    hit = 1'b0;
    for (int r = 0; r < NREGS; r++)
      if (a == ADDR_W'(r)) hit = pv[r];
    return hit;
  endfunction

  function automatic logic [DATA_W-1:0] reg_at(input logic [DATA_W-1:0] rv [NREGS],
                                               input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] val;
    val = '0;
    for (int r = 0; r < NREGS; r++)
      if (a == ADDR_W'(r)) val = rv[r];
    return val;
  endfunction

  always_comb begin
    wb_ok    = wb_en & addr_ok(wb_addr);
    dst_ok   = dst_en & addr_ok(dst_addr);
    // A writeback landing this cycle releases its register immediately.
    dst_haz  = dst_ok & pend_at(pending, dst_addr) & !(wb_ok && (wb_addr == dst_addr));
    src_haz  = '0;
    operands = '0;
    for (int p = 0; p < NRD; p++) begin
      src_addr[p] = rd_addr[p*ADDR_W +: ADDR_W];
      src_haz[p]  = rd_use[p] & pend_at(pending, src_addr[p])
                  & !(wb_ok && (wb_addr == src_addr[p]));
      if (rd_use[p] && addr_ok(src_addr[p])) begin
        if (wb_ok && (wb_addr == src_addr[p]))
          operands[p*DATA_W +: DATA_W] = wb_data;
        else
          operands[p*DATA_W +: DATA_W] = reg_at(regs, src_addr[p]);
      end
    end
    issue_ready = !((|src_haz) | dst_haz);
    accept      = issue_valid & issue_ready;
    dbg_val     = addr_ok(dbg_addr) ? reg_at(regs, dbg_addr) : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      pending  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      dbg_data <= '0;
    end else begin
      rd_valid <= accept;
      if (accept) rd_data <= operands;
      dbg_data <= dbg_val;
      for (int r = 0; r < NREGS; r++) begin
        if (wb_ok && (wb_addr == ADDR_W'(r))) begin
          regs[r]    <= wb_data;
          pending[r] <= 1'b0;
        end
        // A new reservation overrides a same-edge clear of the same register.
        if (accept && dst_ok && (dst_addr == ADDR_W'(r)))
          pending[r] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus randomized traffic against a
// behavioural model, on a default instance and an R0_ZERO/NRD=3/NREGS=6 instance.
module tb_regfile_scoreboard;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // Shared stimulus; phase selects which instance is active (0: default, 1: variant).
  logic        phase;
  logic        issue_valid, dst_en, wb_en;
  logic [2:0]  rd_use;
  logic [8:0]  rd_addr;
  logic [2:0]  dst_addr, wb_addr, dbg_addr;
  logic [15:0] wb_data;

  logic        iv_a, iv_b, we_a, we_b;
  logic        ready_a, ready_b, rv_a, rv_b;
  logic [31:0] rdd_a;
  logic [47:0] rdd_b;
  logic [7:0]  pend_a;
  logic [5:0]  pend_b;
  logic [15:0] dbg_a, dbg_b;

  assign iv_a = issue_valid & ~phase;
  assign iv_b = issue_valid & phase;
  assign we_a = wb_en & ~phase;
  assign we_b = wb_en & phase;

  regfile_scoreboard #(.DATA_W(16), .NREGS(8), .ADDR_W(3), .NRD(2), .R0_ZERO(0)) dut_a (
    .clock(clock), .reset(reset), .issue_valid(iv_a), .issue_ready(ready_a),
    .rd_use(rd_use[1:0]), .rd_addr(rd_addr[5:0]), .dst_en(dst_en), .dst_addr(dst_addr),
    .rd_data(rdd_a), .rd_valid(rv_a), .wb_en(we_a), .wb_addr(wb_addr), .wb_data(wb_data),
    .pending(pend_a), .dbg_addr(dbg_addr), .dbg_data(dbg_a)
  );

  regfile_scoreboard #(.DATA_W(16), .NREGS(6), .ADDR_W(3), .NRD(3), .R0_ZERO(1)) dut_b (
    .clock(clock), .reset(reset), .issue_valid(iv_b), .issue_ready(ready_b),
    .rd_use(rd_use), .rd_addr(rd_addr), .dst_en(dst_en), .dst_addr(dst_addr),
    .rd_data(rdd_b), .rd_valid(rv_b), .wb_en(we_b), .wb_addr(wb_addr), .wb_data(wb_data),
    .pending(pend_b), .dbg_addr(dbg_addr), .dbg_data(dbg_b)
  );

  logic        obs_ready, obs_rv, obs_rdy_s;
  logic [47:0] obs_rd;
  logic [7:0]  obs_pend;
  logic [15:0] obs_dbg;
  assign obs_ready = phase ? ready_b : ready_a;
  assign obs_rv    = phase ? rv_b : rv_a;
  assign obs_rd    = phase ? rdd_b : {16'h0, rdd_a};
  assign obs_pend  = phase ? {2'b00, pend_b} : pend_a;
  assign obs_dbg   = phase ? dbg_b : dbg_a;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // Behavioural model of the active instance.
  int          cfg_nregs, cfg_nrd;
  bit          cfg_r0;
  logic [15:0] m_reg [8];
  bit          m_pend [8];
  logic [15:0] m_rd [3];
  bit          m_rv;
  logic [15:0] m_dbg;

  function automatic bit m_ok(input int a);
    return (a < cfg_nregs) && !(cfg_r0 && a == 0);
  endfunction

  function automatic bit m_wbclr(input int a);
    return wb_en && (int'(wb_addr) == a) && m_ok(a);
  endfunction

  function automatic bit m_busy(input int a);
    return m_ok(a) && m_pend[a] && !m_wbclr(a);
  endfunction

  function automatic logic [7:0] m_pend_vec();
    logic [7:0] v;
    for (int r = 0; r < 8; r++) v[r] = m_pend[r];
    return v;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 8; r++) begin
      m_reg[r]  = 16'h0;
      m_pend[r] = 1'b0;
    end
    for (int p = 0; p < 3; p++) m_rd[p] = 16'h0;
    m_rv  = 1'b0;
    m_dbg = 16'h0;
  endtask

  // Evaluate current inputs against the model and advance it by one clock edge.
  task automatic m_step(output bit rdy);
    bit acc;
    int a;
    rdy = 1'b1;
    for (int p = 0; p < cfg_nrd; p++) begin
      a = int'(rd_addr[p*3 +: 3]);
      if (rd_use[p] && m_busy(a)) rdy = 1'b0;
    end
    if (dst_en && m_busy(int'(dst_addr))) rdy = 1'b0;
    acc  = issue_valid && rdy;
    m_rv = acc;
    if (acc) begin
      for (int p = 0; p < 3; p++) begin
        a = int'(rd_addr[p*3 +: 3]);
        if (p >= cfg_nrd || !rd_use[p] || !m_ok(a)) m_rd[p] = 16'h0;
        else if (m_wbclr(a))                         m_rd[p] = wb_data;
        else                                         m_rd[p] = m_reg[a];
      end
    end
    m_dbg = m_ok(int'(dbg_addr)) ? m_reg[dbg_addr] : 16'h0;
    if (wb_en && m_ok(int'(wb_addr))) begin
      m_reg[wb_addr]  = wb_data;
      m_pend[wb_addr] = 1'b0;
    end
    if (acc && dst_en && m_ok(int'(dst_addr))) m_pend[dst_addr] = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit iv, input logic [2:0] u, input logic [8:0] a, input bit den,
                       input logic [2:0] dst, input bit wen, input logic [2:0] wa,
                       input logic [15:0] wd, input logic [2:0] da);
    issue_valid = iv;
    rd_use      = u;
    rd_addr     = a;
    dst_en      = den;
    dst_addr    = dst;
    wb_en       = wen;
    wb_addr     = wa;
    wb_data     = wd;
    dbg_addr    = da;
  endtask

  task automatic idle();
    drive(1'b0, 3'b000, 9'd0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 3'd0);
  endtask

  // One clock: check issue_ready at the negedge, registered outputs just after the posedge.
  task automatic cycle();
    bit rdy;
    @(negedge clock);
    obs_rdy_s = obs_ready;
    m_step(rdy);
    chk("issue_ready", {47'h0, obs_ready}, {47'h0, rdy});
    @(posedge clock);
    #1;
    chk("rd_valid", {47'h0, obs_rv}, {47'h0, m_rv});
    chk("rd_data", obs_rd, {m_rd[2], m_rd[1], m_rd[0]});
    chk("pending", {40'h0, obs_pend}, {40'h0, m_pend_vec()});
    chk("dbg_data", {32'h0, obs_dbg}, {32'h0, m_dbg});
  endtask

  task automatic rand_cycle();
    logic [2:0] wa;
    logic [2:0] pl [$];
    for (int r = 0; r < 8; r++)
      if (m_pend[r]) pl.push_back(3'(r));
    wa = 3'($urandom_range(0, 7));
    if (pl.size() > 0 && $urandom_range(0, 3) != 0)
      wa = pl[$urandom_range(0, pl.size() - 1)];
    drive($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), 9'($urandom_range(0, 511)),
          $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom_range(0, 2) != 0,
          wa, 16'($urandom), 3'($urandom_range(0, 7)));
    cycle();
  endtask

  initial begin
    phase = 1'b0;
    cfg_nregs = 8; cfg_nrd = 2; cfg_r0 = 1'b0;
    idle();
    reset = 1'b1;
    m_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_pending", {40'h0, obs_pend}, 48'h0);
    chk("rst_rd_valid", {47'h0, obs_rv}, 48'h0);
    chk("rst_ready", {47'h0, obs_ready}, 48'h1);

    // Reserve r2 and r3 (r1 written meanwhile), then reset in the middle of a cycle.
    drive(1'b1, 3'b000, 9'd0, 1'b1, 3'd2, 1'b0, 3'd0, 16'h0, 3'd0);
    cycle();
    drive(1'b1, 3'b001, 9'd1, 1'b1, 3'd3, 1'b1, 3'd1, 16'h5555, 3'd0);
    cycle();
    chk("t1_pend_0c", {40'h0, obs_pend}, 48'h0C);
    chk("t1_rv_before", {47'h0, obs_rv}, 48'h1);
    idle();
    #3 reset = 1'b1;
    #1;
    chk("t1_async_pend", {40'h0, obs_pend}, 48'h0);
    chk("t1_async_rv", {47'h0, obs_rv}, 48'h0);
    chk("t1_async_rd", obs_rd, 48'h0);
    m_reset();
    @(posedge clock);
    #1 reset = 1'b0;
    drive(1'b1, 3'b011, {3'd0, 3'd3, 3'd1}, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 3'd1);
    cycle();
    chk("t1_regs_zero", obs_rd, 48'h0);

    // Write r3 then read it back.
    drive(1'b0, 3'b000, 9'd0, 1'b0, 3'd0, 1'b1, 3'd3, 16'h1234, 3'd0);
    cycle();
    drive(1'b1, 3'b001, 9'd3, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 3'd3);
    cycle();
    chk("t2_data", {32'h0, obs_rd[15:0]}, 48'h1234);
    chk("t2_rv", {47'h0, obs_rv}, 48'h1);
    idle();
    cycle();
    chk("t2_rv_pulse", {47'h0, obs_rv}, 48'h0);

    // RAW stall on r5 released by the writeback, with bypass.
    drive(1'b1, 3'b000, 9'd0, 1'b1, 3'd5, 1'b0, 3'd0, 16'h0, 3'd0);
    cycle();
    drive(1'b1, 3'b001, 9'd5, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 3'd0);
    cycle();
    chk("t3_stall1", {47'h0, obs_rdy_s}, 48'h0);
    cycle();
    chk("t3_stall2", {47'h0, obs_rdy_s}, 48'h0);
    drive(1'b1, 3'b001, 9'd5, 1'b0, 3'd0, 1'b1, 3'd5, 16'hBEEF, 3'd0);
    cycle();
    chk("t3_ready", {47'h0, obs_rdy_s}, 48'h1);
    chk("t3_bypass", {32'h0, obs_rd[15:0]}, 48'hBEEF);
    chk("t3_pend5", {47'h0, obs_pend[5]}, 48'h0);

    // Same-edge clear and set of r2: set wins, new value lands.
    drive(1'b1, 3'b000, 9'd0, 1'b1, 3'd2, 1'b0, 3'd0, 16'h0, 3'd0);
    cycle();
    drive(1'b1, 3'b001, 9'd2, 1'b1, 3'd2, 1'b1, 3'd2, 16'd7, 3'd0);
    cycle();
    chk("t4_ready", {47'h0, obs_rdy_s}, 48'h1);
    chk("t4_pend2", {47'h0, obs_pend[2]}, 48'h1);
    chk("t4_data", {32'h0, obs_rd[15:0]}, 48'd7);
    drive(1'b0, 3'b000, 9'd0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 3'd2);
    cycle();
    chk("t4_reg2", {32'h0, obs_dbg}, 48'd7);

    for (int i = 0; i < 300; i++) rand_cycle();

    // Variant instance: R0_ZERO=1, NRD=3, NREGS=6.
    phase = 1'b1;
    cfg_nregs = 6; cfg_nrd = 3; cfg_r0 = 1'b1;
    idle();
    reset = 1'b1;
    m_reset();
    @(posedge clock);
    #1 reset = 1'b0;

    drive(1'b0, 3'b000, 9'd0, 1'b0, 3'd0, 1'b1, 3'd0, 16'hFFFF, 3'd0);
    cycle();
    drive(1'b1, 3'b000, 9'd0, 1'b1, 3'd0, 1'b0, 3'd0, 16'h0, 3'd0);
    cycle();
    chk("t5_dst0_ready", {47'h0, obs_rdy_s}, 48'h1);
    drive(1'b1, 3'b001, 9'd0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 3'd0);
    cycle();
    chk("t5_src0_ready", {47'h0, obs_rdy_s}, 48'h1);
    chk("t5_r0_data", {32'h0, obs_rd[15:0]}, 48'h0);
    chk("t5_pend0", {47'h0, obs_pend[0]}, 48'h0);

    drive(1'b0, 3'b000, 9'd0, 1'b0, 3'd0, 1'b1, 3'd4, 16'hA5A5, 3'd0);
    cycle();
    drive(1'b1, 3'b001, 9'd4, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 3'd4);
    cycle();
    chk("t6_r4", obs_rd, 48'h0000_0000_A5A5);
    drive(1'b1, 3'b010, {3'd4, 3'd7, 3'd4}, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 3'd7);
    cycle();
    chk("t6_invalid_zero", obs_rd, 48'h0);
    chk("t6_dbg_invalid", {32'h0, obs_dbg}, 48'h0);
    drive(1'b1, 3'b000, 9'd0, 1'b1, 3'd4, 1'b0, 3'd0, 16'h0, 3'd0);
    cycle();
    drive(1'b1, 3'b000, {3'd4, 3'd4, 3'd4}, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 3'd0);
    cycle();
    chk("t6_unused_no_stall", {47'h0, obs_rdy_s}, 48'h1);
    drive(1'b1, 3'b100, {3'd4, 3'd1, 3'd1}, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 3'd0);
    cycle();
    chk("t6_port2_stall", {47'h0, obs_rdy_s}, 48'h0);

    for (int i = 0; i < 300; i++) rand_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
